// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: requester and memory-side signal bundle for dmem_port_arbiter
//   cpu_*  : CPU MEM-stage load/store port (req/we/addr/wdata in, rdata/ready/stall out)
//   dbg_*  : debug/loader port (req/we/addr/wdata in, rdata/ready out)
//   mem_*  : data memory port (en/we/addr/wdata out, rdata in)
//   slave  : arbiter view, master : requester/memory environment view
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin sharing of one data memory between CPU and debug ports
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of dmem_port_arbiter_if (cpu_*, dbg_* requester ports, mem_* memory port)
//   MEM_LAT (1..15) : cycles from mem_en to valid mem_rdata
module dmem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic                 clk,
  input logic                 reset,
  dmem_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              cpu_ready_q, dbg_ready_q;
  logic              grant_dbg, capture;
  // owner/last encoding: 0 = CPU, 1 = DBG; on a tie the side that was not served last wins
  assign grant_dbg = bus.dbg_req & (~bus.cpu_req | ~last_q);
  assign capture   = (state_q == WAIT) & (cnt_q == 4'd1) & ~we_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.cpu_req | bus.dbg_req) begin
        owner_d = grant_dbg;
        last_d  = grant_dbg;
        we_d    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
        addr_d  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
        wdata_d = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = 4'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? RESP : WAIT;
      end
      RESP: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end
  // Outputs are registered from the next state so they line up with ISSUE/RESP exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
    end else begin
      mem_en_q    <= state_d == ISSUE;
      mem_we_q    <= (state_d == ISSUE) & we_d;
      mem_addr_q  <= (state_d == ISSUE) ? addr_d : mem_addr_q;
      mem_wdata_q <= (state_d == ISSUE) ? wdata_d : mem_wdata_q;
      cpu_rdata_q <= (capture & ~owner_q) ? bus.mem_rdata : cpu_rdata_q;
      dbg_rdata_q <= (capture & owner_q) ? bus.mem_rdata : dbg_rdata_q;
      cpu_ready_q <= (state_d == RESP) & ~owner_q;
      dbg_ready_q <= (state_d == RESP) & owner_q;
    end
  end
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dbg_ready = dbg_ready_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ready_q;
endmodule
